// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, latency constants and alignment helper for the LSU memory master
package lsu_pkg;

    typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_RSV = 2'd3} size_e;
    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RESP = 2'd3} lsu_state_e;

    // Cycles from request accept to resp_valid.
    localparam int LAT_LOAD      = 2;
    localparam int LAT_STORE_W   = 2;
    localparam int LAT_STORE_SUB = 3;
    localparam int LAT_ERR       = 1;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == SZ_H) && addr_lo[0]) || ((size == SZ_W) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_lane_unit.sv
// rtl/lsu_lane_unit.sv - combinational load extract/extend and sub-word store merge
module lsu_lane_unit
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [31:0] old_word,
    input  size_e       size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    always_comb begin
        load_data  = rdata;
        store_data = wdata;
        case (size)
            SZ_B: begin
                load_data  = {{24{sign_ext & rdata[7]}}, rdata[7:0]};
                store_data = {old_word[31:8], wdata[7:0]};
            end
            SZ_H: begin
                load_data  = {{16{sign_ext & rdata[15]}}, rdata[15:0]};
                store_data = {old_word[31:16], wdata[15:0]};
            end
            default: begin
                load_data  = rdata;
                store_data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - single-outstanding load/store initiator with read-modify-write sub-word stores
// Optional misalignment trap: define MISALIGN_TRAP_EN.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RD   = RD;
    localparam logic [1:0] ST_WR   = WR;
    localparam logic [1:0] ST_RESP = RESP;

    logic [1:0]            state;
    logic                  live_q;
    logic                  we_q;
    size_e                 size_q;
    logic                  signed_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic                  reject;
    logic [31:0]           load_data;
    logic [31:0]           store_data;

    always_comb begin
        reject = (req_size == SZ_RSV);
`ifdef MISALIGN_TRAP_EN
        reject = reject || is_misaligned(req_size, req_addr[1:0]);
`endif
    end

    lsu_lane_unit u_lane (
        .rdata     (mem_rdata),
        .old_word  (mem_rdata),
        .size      (size_q),
        .sign_ext  (signed_q),
        .wdata     (wdata_q),
        .load_data (load_data),
        .store_data(store_data)
    );

    // live_q keeps req_ready low while reset is held and for the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            live_q      <= 1'b0;
            we_q        <= 1'b0;
            size_q      <= SZ_B;
            signed_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            live_q <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        we_q     <= req_we;
                        size_q   <= size_e'(req_size);
                        signed_q <= req_signed;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        rdata_q  <= '0;
                        err_q    <= 1'b0;
                        if (reject) begin
                            err_q <= 1'b1;
                            state <= ST_RESP;
                        end else if (req_we && (req_size == SZ_W)) begin
                            mem_wdata_q <= req_wdata;
                            state       <= ST_WR;
                        end else begin
                            state <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (we_q) begin
                        mem_wdata_q <= store_data;
                        state       <= ST_WR;
                    end else begin
                        rdata_q <= load_data;
                        state   <= ST_RESP;
                    end
                end
                ST_WR: state <= ST_RESP;
                default: begin
                    if (resp_ready) state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = live_q && (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_we     = (state == ST_WR);
    assign mem_addr   = addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb/tb_lsu_mem_master.sv - table-driven and scoreboarded bench for lsu_mem_master with byte memory model
module tb_lsu_mem_master;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        preload;
    logic [7:0]  mem [0:4095];
    logic [7:0]  sh  [0:4095];
    logic [11:0] ma;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        logic [31:0] mwdata;
        int          stall;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nwe;
        logic [31:0] mwdata;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[16];
    int   ntbl;
    int   n_vec;
    int   n_err;

    always #5 clk = ~clk;

    lsu_mem_master dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_signed(req_signed),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    assign ma        = mem_addr[11:0];
    assign mem_rdata = {mem[ma + 12'd3], mem[ma + 12'd2], mem[ma + 12'd1], mem[ma]};

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
            mem[12'h100] <= 8'hEF;
            mem[12'h101] <= 8'hBE;
            mem[12'h102] <= 8'hAD;
            mem[12'h103] <= 8'hDE;
        end else if (mem_we) begin
            mem[ma]         <= mem_wdata[7:0];
            mem[ma + 12'd1] <= mem_wdata[15:8];
            mem[ma + 12'd2] <= mem_wdata[23:16];
            mem[ma + 12'd3] <= mem_wdata[31:24];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input logic err, input int lat,
                                input logic [31:0] mwdata, input int stall);
        vec_t v;
        v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.err = err; v.lat = lat; v.mwdata = mwdata; v.stall = stall;
        return v;
    endfunction

    // Reference behaviour over the shadow byte memory; stores update the shadow.
    function automatic vec_t model(input vec_t vi);
        vec_t        v;
        logic        bad;
        logic [11:0] a;
        logic [31:0] old;
        v   = vi;
        a   = v.addr[11:0];
        old = {sh[a + 12'd3], sh[a + 12'd2], sh[a + 12'd1], sh[a]};
        bad = (v.size == 2'b11);
`ifdef MISALIGN_TRAP_EN
        bad = bad || ((v.size == 2'b01) && v.addr[0]) || ((v.size == 2'b10) && (v.addr[1:0] != 2'b00));
`endif
        v.rdata = 32'h0; v.err = 1'b0; v.mwdata = 32'h0;
        if (bad) begin
            v.err = 1'b1; v.lat = LAT_ERR;
        end else if (v.we) begin
            if (v.size == 2'b00)      v.mwdata = {old[31:8], v.wdata[7:0]};
            else if (v.size == 2'b01) v.mwdata = {old[31:16], v.wdata[15:0]};
            else                      v.mwdata = v.wdata;
            v.lat = (v.size == 2'b10) ? LAT_STORE_W : LAT_STORE_SUB;
            sh[a] = v.mwdata[7:0]; sh[a + 12'd1] = v.mwdata[15:8];
            sh[a + 12'd2] = v.mwdata[23:16]; sh[a + 12'd3] = v.mwdata[31:24];
        end else begin
            v.lat = LAT_LOAD;
            if (v.size == 2'b00)      v.rdata = {{24{v.sgn & old[7]}}, old[7:0]};
            else if (v.size == 2'b01) v.rdata = {{16{v.sgn & old[15]}}, old[15:0]};
            else                      v.rdata = old;
        end
        return v;
    endfunction

    task automatic do_req(input vec_t v);
        exp_t        e;
        int          cyc;
        int          we_cnt;
        int          we_at;
        logic [31:0] we_data;
        logic [31:0] we_addr;
        bit          ok;
        bit          seen;
        req_valid = 1'b1; req_we = v.we; req_size = v.size; req_signed = v.sgn;
        req_addr = v.addr; req_wdata = v.wdata;
        resp_ready = (v.stall == 0);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            ok = req_ready;
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("accept", 32'(ok), 32'd1);
        if (!ok) return;
        e.rdata = v.rdata; e.err = v.err; e.lat = v.lat; e.mwdata = v.mwdata; e.addr = v.addr;
        e.nwe = (v.we && !v.err) ? 1 : 0;
        sb.push_back(e);
        cyc = 1; we_cnt = 0; we_at = 0; we_data = '0; we_addr = '0; seen = 1'b0;
        while (!seen && cyc <= 8) begin
            if (mem_we) begin
                we_cnt++; we_at = cyc; we_data = mem_wdata; we_addr = mem_addr;
            end
            if (resp_valid) begin
                seen = 1'b1;
            end else begin
                chk("ready_busy", 32'(req_ready), 32'd0);
                @(negedge clk);
                cyc++;
            end
        end
        chk("resp_seen", 32'(seen), 32'd1);
        if (!seen) return;
        e = sb.pop_front();
        chk("latency", 32'(cyc), 32'(e.lat));
        chk("rdata", resp_rdata, e.rdata);
        chk("err", 32'(resp_err), 32'(e.err));
        chk("we_pulses", 32'(we_cnt), 32'(e.nwe));
        if (e.nwe == 1) begin
            chk("we_cycle", 32'(we_at), 32'(e.lat - 1));
            chk("we_data", we_data, e.mwdata);
            chk("we_addr", we_addr, e.addr);
        end
        for (int s = 0; s < v.stall; s++) begin
            @(negedge clk);
            chk("stall_we", 32'(mem_we), 32'd0);
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_rdata", resp_rdata, e.rdata);
            chk("hold_err", 32'(resp_err), 32'(e.err));
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("retired", 32'(resp_valid), 32'd0);
        chk("ready_idle", 32'(req_ready), 32'd1);
        resp_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        n_vec = 0; n_err = 0;
        for (int i = 0; i < 4096; i++) sh[i] = 8'h00;
        ntbl = 0;
        tbl[ntbl++] = mk(0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 2, 32'h0, 0);
        tbl[ntbl++] = mk(0, 2'b00, 1, 32'h100, 32'h0, 32'hFFFFFFEF, 0, 2, 32'h0, 0);
        tbl[ntbl++] = mk(0, 2'b00, 0, 32'h100, 32'h0, 32'h000000EF, 0, 2, 32'h0, 0);
        tbl[ntbl++] = mk(0, 2'b01, 1, 32'h100, 32'h0, 32'hFFFFBEEF, 0, 2, 32'h0, 0);
        tbl[ntbl++] = mk(0, 2'b01, 0, 32'h100, 32'h0, 32'h0000BEEF, 0, 2, 32'h0, 1);
        tbl[ntbl++] = mk(0, 2'b00, 1, 32'h103, 32'h0, 32'hFFFFFFDE, 0, 2, 32'h0, 0);
        tbl[ntbl++] = mk(1, 2'b00, 0, 32'h100, 32'hCAFE0055, 32'h0, 0, 3, 32'hDEADBE55, 0);
        tbl[ntbl++] = mk(0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBE55, 0, 2, 32'h0, 0);
        tbl[ntbl++] = mk(1, 2'b01, 1, 32'h100, 32'hA5A51234, 32'h0, 0, 3, 32'hDEAD1234, 2);
        tbl[ntbl++] = mk(0, 2'b10, 0, 32'h100, 32'h0, 32'hDEAD1234, 0, 2, 32'h0, 0);
        tbl[ntbl++] = mk(1, 2'b10, 0, 32'h200, 32'h12345678, 32'h0, 0, 2, 32'h12345678, 5);
        tbl[ntbl++] = mk(0, 2'b10, 0, 32'h200, 32'h0, 32'h12345678, 0, 2, 32'h0, 0);
        tbl[ntbl++] = mk(0, 2'b11, 1, 32'h100, 32'h0, 32'h0, 1, 1, 32'h0, 3);
        tbl[ntbl++] = mk(1, 2'b11, 0, 32'h200, 32'hFFFFFFFF, 32'h0, 1, 1, 32'h0, 0);
        tbl[ntbl++] = mk(0, 2'b10, 0, 32'h200, 32'h0, 32'h12345678, 0, 2, 32'h0, 0);
`ifdef MISALIGN_TRAP_EN
        tbl[ntbl++] = mk(0, 2'b10, 0, 32'h102, 32'h0, 32'h0, 1, 1, 32'h0, 0);
`else
        tbl[ntbl++] = mk(0, 2'b10, 0, 32'h102, 32'h0, 32'h0000DEAD, 0, 2, 32'h0, 0);
`endif

        rst_n = 1'b0; preload = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        preload = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(req_ready), 32'd1);

        for (int i = 0; i < ntbl; i++) do_req(tbl[i]);

        // Reset lands while the sub-word store is in its read cycle.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h100; req_wdata = 32'h00000077;
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_rst_rd_we", 32'(mem_we), 32'd0);
        chk("mid_rst_rd_addr", mem_addr, 32'h100);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready_low", 32'(req_ready), 32'd0);
        chk("mid_rst_we_low", 32'(mem_we), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("mid_rst_hold_we", 32'(mem_we), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_release_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_mem_intact", {mem[12'h103], mem[12'h102], mem[12'h101], mem[12'h100]}, 32'hDEAD1234);
        do_req(mk(0, 2'b10, 0, 32'h100, 32'h0, 32'hDEAD1234, 0, 2, 32'h0, 0));

        for (int k = 0; k < 24; k++) begin
            v.we    = 1'($urandom_range(0, 1));
            v.size  = (k % 8 == 7) ? 2'b11 : 2'($urandom_range(0, 2));
            v.sgn   = 1'($urandom_range(0, 1));
            v.addr  = 32'h300 + 32'($urandom_range(0, 60));
            v.wdata = $urandom;
            v.stall = (k % 4 == 0) ? int'($urandom_range(1, 3)) : 0;
            v = model(v);
            do_req(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
